// File: rtl/regfile_wb_port.sv
// regfile_wb_port
//   32 x 32-bit integer register file with one write-back port, two
//   combinational read ports, a registered debug readout port and a
//   committed-write counter.
//
//   Optional feature (macro RF_WB_BYPASS_EN):
//     defined   -> a write in flight is bypassed to rd1/rd2 in the same cycle
//                  (write-before-read), suppressed while rst is high.
//     undefined -> rd1/rd2 show the stored value until the write edge.
//
// Parameters
//   SP_INIT   reset value of x2 (sp)
//   GP_INIT   reset value of x3 (gp)
//
// Ports
//   clk       single clock, rising edge
//   rst       asynchronous active-high reset
//   regwrite  write enable from write-back
//   rd        write address
//   result    write data
//   rs1, rs2  read addresses from decode
//   rd1, rd2  combinational read data
//   dbg_addr  debug readout address
//   dbg_data  registered readout of entry[dbg_addr] (1-cycle latency)
//   wr_count  number of committed writes (rd != 0), wraps modulo 2^32
//
// Handshake: there is no valid/ready pair. The write port is a plain
// enable: a write commits on every rising clk edge where regwrite=1 and
// rd!=0 and rst=0; it is never back-pressured. Read ports are always valid.

module regfile_wb_port #(
  parameter logic [31:0] SP_INIT = 32'h0000_0000,
  parameter logic [31:0] GP_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwrite,
  input  logic [4:0]  rd,
  input  logic [31:0] result,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [31:0] wr_count
);

  logic [31:0] regs [32];
  logic        wr_en;
  logic [31:0] stored_a;
  logic [31:0] stored_b;

  // Writes to x0 are architecturally discarded and do not count.
  assign wr_en = regwrite && (rd != 5'd0);

  function automatic logic [31:0] reset_val(input int idx);
    if (idx == 2)      return SP_INIT;
    else if (idx == 3) return GP_INIT;
    else               return 32'h0000_0000;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= reset_val(i);
      end
      wr_count <= 32'h0000_0000;
      dbg_data <= 32'h0000_0000;
    end else begin
      if (wr_en) begin
        regs[rd] <= result;
        wr_count <= wr_count + 32'd1;
      end
      // Samples the pre-edge contents, so a same-cycle write to dbg_addr
      // shows up one cycle later (no debug bypass).
      dbg_data <= (dbg_addr == 5'd0) ? 32'h0000_0000 : regs[dbg_addr];
    end
  end

  // x0 is forced to zero on the read side regardless of storage contents.
  assign stored_a = (rs1 == 5'd0) ? 32'h0000_0000 : regs[rs1];
  assign stored_b = (rs2 == 5'd0) ? 32'h0000_0000 : regs[rs2];

`ifdef RF_WB_BYPASS_EN
  logic byp_a;
  logic byp_b;

  // wr_en already excludes rd=0, so x0 is never bypassed.
  assign byp_a = !rst && wr_en && (rd == rs1);
  assign byp_b = !rst && wr_en && (rd == rs2);
  assign rd1   = byp_a ? result : stored_a;
  assign rd2   = byp_b ? result : stored_b;
`else
  assign rd1 = stored_a;
  assign rd2 = stored_b;
`endif

endmodule

// File: doc/regfile_wb_port.md
REGFILE_WB_PORT -- requirements
Module: regfile_wb_port

Interface
REQ-001 The block SHALL have parameter SP_INIT, default 32'h0000_0000, giving the reset value of x2 (sp).
REQ-002 The block SHALL have parameter GP_INIT, default 32'h0000_0000, giving the reset value of x3 (gp).
REQ-003 Port clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port regwrite, input, 1: write enable, driven by the write-back stage.
REQ-006 Port rd, input, 5: write address, driven by the write-back stage.
REQ-007 Port result, input, 32: write data, driven by the write-back stage.
REQ-008 Port rs1, input, 5: read port A address, driven by decode.
REQ-009 Port rs2, input, 5: read port B address, driven by decode.
REQ-010 Port rd1, output, 32: read port A data.
REQ-011 Port rd2, output, 32: read port B data.
REQ-012 Port dbg_addr, input, 5: debug/PS readout address.
REQ-013 Port dbg_data, output, 32: debug readout data, registered.
REQ-014 Port wr_count, output, 32: count of committed architectural writes.

Function
REQ-015 Storage SHALL be 32 entries x 32 bits, x0..x31.
REQ-016 On a rising clk edge with regwrite=1 and rd!=0, entry[rd] SHALL take the value of result.
REQ-017 A write with rd=0 SHALL be discarded; x0 SHALL always read as 0 on every port.
REQ-018 rd1 and rd2 SHALL be combinational reads of entry[rs1] and entry[rs2], with zero added latency.
REQ-019 rs1==rs2 SHALL return identical data on both ports.
REQ-020 dbg_data SHALL register entry[dbg_addr] on each rising clk edge, giving 1-cycle latency; dbg_addr=0 SHALL yield 0.
REQ-021 On a same-cycle write to dbg_addr, dbg_data SHALL capture the pre-write value (no bypass on the debug port).
REQ-022 wr_count SHALL increment by 1 on each edge where regwrite=1 and rd!=0, and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-023 regwrite=1 with rd=0 SHALL NOT increment wr_count.
REQ-024 No other state SHALL change when regwrite=0.

Reset
REQ-025 While rst=1, all entries SHALL be 0, except x2=SP_INIT and x3=GP_INIT, and wr_count=0 and dbg_data=0, asynchronously.
REQ-026 A write presented in the same cycle as rst assertion SHALL be lost.
REQ-027 The first write SHALL be accepted on the first rising edge after rst deasserts.
REQ-028 rd1 and rd2 SHALL reflect the reset contents combinationally while rst=1.

Configuration
REQ-029 When macro RF_WB_BYPASS_EN is defined: if regwrite=1, rd!=0 and rd equals rs1 (or rs2), then rd1 (or rd2) SHALL equal result in that same cycle (write-before-read).
REQ-030 When RF_WB_BYPASS_EN is undefined, rd1/rd2 SHALL return the stored pre-write value until the edge completes, so the hazard unit must stall or forward one extra cycle.
REQ-031 The bypass SHALL be suppressed while rst=1 and SHALL never apply to rd=0.

Verification
REQ-032 rst pulse mid-run -> all reads 0 except x2=SP_INIT and x3=GP_INIT; wr_count=0.
REQ-033 Write x5=32'hDEAD_BEEF, then rs1=5 the next cycle -> rd1=32'hDEAD_BEEF; wr_count=1.
REQ-034 regwrite=1, rd=0, result=32'h1234_5678 -> rs1=0 reads 0; wr_count unchanged.
REQ-035 Same cycle: regwrite=1, rd=7, result=32'hA5A5_A5A5, rs1=rs2=7 -> both ports read A5A5_A5A5 in that cycle if RF_WB_BYPASS_EN is defined, else the old value, then A5A5_A5A5 next cycle.
REQ-036 dbg_addr=5 held across a write to x5 of 32'h0000_0042 -> dbg_data shows the old value, then 32'h0000_0042 one cycle later.
REQ-037 Preload wr_count near 32'hFFFF_FFFF via 2^32-1 writes (or force) then one more write -> wr_count=0.
